// File: rtl/zoom_in_nn_scaler_pkg.sv
// Shared definitions for the zoom family of frame-buffer blocks.
// Holds the FSM encoding, the factor field width and the factor range check.
package zoom_in_nn_scaler_pkg;

  localparam int FACTOR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  function automatic logic factor_ok(
    input logic [FACTOR_W-1:0] f,
    input int                  max_f
  );
    return (f != '0) && (f <= FACTOR_W'(max_f));
  endfunction

endpackage

// File: rtl/zoom_in_nn_scaler_if.sv
// Job control, ROM read port and frame RAM write port of the scaler.
// The master side is the host plus ROM; the slave side is the scaler.
interface zoom_in_nn_scaler_if #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 16,
  parameter int ROM_AW = 17,
  parameter int RAM_AW = 19
);
  import zoom_in_nn_scaler_pkg::*;

  logic                start;
  logic [FACTOR_W-1:0] factor;
  logic [DIM_W-1:0]    img_width;
  logic [DIM_W-1:0]    img_height;
  logic [ROM_AW-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_data_in;
  logic [RAM_AW-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_data;
  logic                ram_wren;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, factor, img_width, img_height,
    output rom_data_in,
    input  rom_addr,
    input  ram_addr, ram_data, ram_wren,
    input  busy, done, err
  );

  modport slave (
    input  start, factor, img_width, img_height,
    input  rom_data_in,
    output rom_addr,
    output ram_addr, ram_data, ram_wren,
    output busy, done, err
  );

endinterface

// File: rtl/zoom_raster_walker.sv
// Walks the output raster row-major and yields the source ROM address
// of each output pixel using only increment and add-W steps.
module zoom_raster_walker
  import zoom_in_nn_scaler_pkg::*;
#(
  parameter int DIM_W  = 16,
  parameter int ROM_AW = 17
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic [DIM_W-1:0]    width,
  input  logic [DIM_W-1:0]    height,
  input  logic [FACTOR_W-1:0] factor,
  output logic                issue_valid,
  output logic                issue_last,
  output logic [ROM_AW-1:0]   rom_addr
);

  logic                active_q, active_d;
  logic [FACTOR_W-1:0] col_rep_q, col_rep_d;
  logic [FACTOR_W-1:0] row_rep_q, row_rep_d;
  logic [DIM_W-1:0]    col_q, col_d;
  logic [DIM_W-1:0]    row_q, row_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [ROM_AW-1:0]   row_base_q, row_base_d;

  logic [FACTOR_W-1:0] rep_end;
  logic                last_col_rep;
  logic                last_col;
  logic                last_row_rep;
  logic                last_row;

  assign rep_end      = factor - FACTOR_W'(1);
  assign last_col_rep = (col_rep_q == rep_end);
  assign last_row_rep = (row_rep_q == rep_end);
  assign last_col     = (col_q == width - DIM_W'(1));
  assign last_row     = (row_q == height - DIM_W'(1));

  assign issue_valid = active_q;
  assign issue_last  = active_q & last_col_rep & last_col
                     & last_row_rep & last_row;
  assign rom_addr    = rom_addr_q;

  always_comb begin
    active_d   = active_q;
    col_rep_d  = col_rep_q;
    row_rep_d  = row_rep_q;
    col_d      = col_q;
    row_d      = row_q;
    rom_addr_d = rom_addr_q;
    row_base_d = row_base_q;
    if (go) begin
      active_d   = 1'b1;
      col_rep_d  = '0;
      row_rep_d  = '0;
      col_d      = '0;
      row_d      = '0;
      rom_addr_d = '0;
      row_base_d = '0;
    end else if (active_q) begin
      if (issue_last) active_d = 1'b0;
      if (!last_col_rep) begin
        col_rep_d = col_rep_q + FACTOR_W'(1);
      end else begin
        col_rep_d = '0;
        if (!last_col) begin
          col_d      = col_q + DIM_W'(1);
          rom_addr_d = rom_addr_q + ROM_AW'(1);
        end else begin
          // End of an output row: repeat the source row or step to the next.
          col_d = '0;
          if (!last_row_rep) begin
            row_rep_d  = row_rep_q + FACTOR_W'(1);
            rom_addr_d = row_base_q;
          end else begin
            row_rep_d  = '0;
            row_d      = row_q + DIM_W'(1);
            row_base_d = row_base_q + ROM_AW'(width);
            rom_addr_d = row_base_d;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q   <= 1'b0;
      col_rep_q  <= '0;
      row_rep_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rom_addr_q <= '0;
      row_base_q <= '0;
    end else begin
      active_q   <= active_d;
      col_rep_q  <= col_rep_d;
      row_rep_q  <= row_rep_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rom_addr_q <= rom_addr_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/zoom_in_nn_scaler.sv
// Nearest-neighbour zoom-in from image ROM to frame RAM.
// FSM, job validation, ROM latency alignment and registered RAM port.
module zoom_in_nn_scaler
  import zoom_in_nn_scaler_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIM_W      = 16,
  parameter int ROM_AW     = 17,
  parameter int RAM_AW     = 19,
  parameter int MAX_FACTOR = 4,
  parameter int ROM_LAT    = 1
) (
  input logic              clock,
  input logic              reset,
  zoom_in_nn_scaler_if.slave bus
);

  localparam int CW = $clog2(ROM_LAT + 2);
  localparam int OW = DIM_W + FACTOR_W;
  localparam int PW = 2 * OW;
  localparam logic [CW-1:0] DRAIN_END = CW'(ROM_LAT);
  localparam logic [PW-1:0] DEPTH     = PW'(64'd1 << RAM_AW);

  state_t                         state_q, state_d;
  logic [FACTOR_W-1:0]            factor_q, factor_d;
  logic [DIM_W-1:0]               width_q, width_d;
  logic [DIM_W-1:0]               height_q, height_d;
  logic [CW-1:0]                  drain_q, drain_d;
  logic [RAM_AW-1:0]              issue_addr_q, issue_addr_d;
  logic [ROM_LAT-1:0]             dly_v_q, dly_v_d;
  logic [ROM_LAT-1:0][RAM_AW-1:0] dly_a_q, dly_a_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic                           ram_wren_q, ram_wren_d;
  logic [RAM_AW-1:0]              ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]              ram_data_q, ram_data_d;

  logic              walk_go;
  logic              issue_valid;
  logic              issue_last;
  logic [ROM_AW-1:0] rom_addr;

  logic [OW-1:0] out_w;
  logic [OW-1:0] out_h;
  logic [PW-1:0] out_px;
  logic          reject;

  // Only the job check multiplies; the walker itself never does.
  assign out_w  = OW'(width_q) * OW'(factor_q);
  assign out_h  = OW'(height_q) * OW'(factor_q);
  assign out_px = PW'(out_w) * PW'(out_h);
  assign reject = !factor_ok(factor_q, MAX_FACTOR)
               || (width_q == '0) || (height_q == '0)
               || (out_px > DEPTH);

  zoom_raster_walker #(
    .DIM_W (DIM_W),
    .ROM_AW(ROM_AW)
  ) u_walker (
    .clock      (clock),
    .reset      (reset),
    .go         (walk_go),
    .width      (width_q),
    .height     (height_q),
    .factor     (factor_q),
    .issue_valid(issue_valid),
    .issue_last (issue_last),
    .rom_addr   (rom_addr)
  );

  always_comb begin
    state_d  = state_q;
    factor_d = factor_q;
    width_d  = width_q;
    height_d = height_q;
    drain_d  = drain_q;
    walk_go  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          factor_d = bus.factor;
          width_d  = bus.img_width;
          height_d = bus.img_height;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (reject) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          walk_go = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_last) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_END) state_d = ST_FIN;
        else drain_d = drain_q + CW'(1);
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_comb begin
    issue_addr_d = issue_addr_q;
    if (walk_go) issue_addr_d = '0;
    else if (issue_valid) issue_addr_d = issue_addr_q + RAM_AW'(1);
    dly_v_d    = dly_v_q;
    dly_a_d    = dly_a_q;
    dly_v_d[0] = issue_valid;
    dly_a_d[0] = issue_addr_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      dly_v_d[i] = dly_v_q[i-1];
      dly_a_d[i] = dly_a_q[i-1];
    end
    // The tail of the delay line meets the ROM data for the same pixel.
    ram_wren_d = dly_v_q[ROM_LAT-1];
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    if (dly_v_q[ROM_LAT-1]) begin
      ram_addr_d = dly_a_q[ROM_LAT-1];
      ram_data_d = bus.rom_data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      factor_q     <= '0;
      width_q      <= '0;
      height_q     <= '0;
      drain_q      <= '0;
      issue_addr_q <= '0;
      dly_v_q      <= '0;
      dly_a_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ram_wren_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      factor_q     <= factor_d;
      width_q      <= width_d;
      height_q     <= height_d;
      drain_q      <= drain_d;
      issue_addr_q <= issue_addr_d;
      dly_v_q      <= dly_v_d;
      dly_a_q      <= dly_a_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ram_wren_q   <= ram_wren_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
    end
  end

  assign bus.rom_addr = rom_addr;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_data = ram_data_q;
  assign bus.ram_wren = ram_wren_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_zoom_in_nn_scaler.sv
// Bench for the zoom-in scaler: ROM_LAT=1 and ROM_LAT=2 builds side by side,
// every RAM write compared with an arithmetic nearest-neighbour model.
module tb_zoom_in_nn_scaler;
  import zoom_in_nn_scaler_pkg::*;

  localparam int DATA_W = 8;
  localparam int DIM_W  = 16;
  localparam int ROM_AW = 17;
  localparam int RAM_AW = 19;
  localparam int MAX_F  = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  zoom_in_nn_scaler_if #(
    .DATA_W(DATA_W), .DIM_W(DIM_W), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW)
  ) bus1 ();
  zoom_in_nn_scaler_if #(
    .DATA_W(DATA_W), .DIM_W(DIM_W), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW)
  ) bus2 ();

  zoom_in_nn_scaler #(
    .DATA_W(DATA_W), .DIM_W(DIM_W), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW),
    .MAX_FACTOR(MAX_F), .ROM_LAT(1)
  ) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

  zoom_in_nn_scaler #(
    .DATA_W(DATA_W), .DIM_W(DIM_W), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW),
    .MAX_FACTOR(MAX_F), .ROM_LAT(2)
  ) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

  logic [DATA_W-1:0] rom_mem [1024];
  logic [DATA_W-1:0] rom1_q, rom2_a, rom2_b;

  always @(posedge clock) begin
    rom1_q <= rom_mem[bus1.rom_addr[9:0]];
    rom2_a <= rom_mem[bus2.rom_addr[9:0]];
    rom2_b <= rom2_a;
  end

  assign bus1.rom_data_in = rom1_q;
  assign bus2.rom_data_in = rom2_b;
  assign bus2.start       = bus1.start;
  assign bus2.factor      = bus1.factor;
  assign bus2.img_width   = bus1.img_width;
  assign bus2.img_height  = bus1.img_height;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int jw, jf;
  bit jrej = 1'b1;
  int exp_idx [2];
  int done_n  [2];
  int err_n   [2];
  int last_wr [2];
  int done_at [2];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output pixel a sits at (x,y); its source is (x/F, y/F).
  function automatic logic [DATA_W-1:0] model_px(input int a);
    int ow, x, y;
    ow = jw * jf;
    x  = a % ow;
    y  = a / ow;
    return rom_mem[(y / jf) * jw + x / jf];
  endfunction

  task automatic sample(input int k, input logic wren,
                        input logic [RAM_AW-1:0] addr,
                        input logic [DATA_W-1:0] data,
                        input logic done, input logic err);
    if (wren) begin
      if (!jrej) begin
        check($sformatf("wr_addr%0d", k), addr, exp_idx[k]);
        check($sformatf("wr_data%0d", k), data, model_px(exp_idx[k]));
      end
      exp_idx[k]++;
      last_wr[k] = cyc;
    end
    if (done) begin
      done_n[k]++;
      done_at[k] = cyc;
    end
    if (err) err_n[k]++;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    cyc++;
    sample(0, bus1.ram_wren, bus1.ram_addr, bus1.ram_data,
           bus1.done, bus1.err);
    sample(1, bus2.ram_wren, bus2.ram_addr, bus2.ram_data,
           bus2.done, bus2.err);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl1"},
          {bus1.ram_wren, bus1.done, bus1.err, bus1.busy}, 0);
    check({tag, "_ctl2"},
          {bus2.ram_wren, bus2.done, bus2.err, bus2.busy}, 0);
    check({tag, "_addr1"}, {bus1.ram_addr, bus1.rom_addr}, 0);
    check({tag, "_addr2"}, {bus2.ram_addr, bus2.rom_addr}, 0);
    check({tag, "_data1"}, bus1.ram_data, 0);
    check({tag, "_data2"}, bus2.ram_data, 0);
  endtask

  task automatic setup_job(input int w, input int h, input int f);
    longint px;
    px   = longint'(w * f) * longint'(h * f);
    jrej = (f == 0) || (f > MAX_F) || (w == 0) || (h == 0)
        || (px > (longint'(1) << RAM_AW));
    jw = w;
    jf = f;
    for (int i = 0; i < 1024; i++) rom_mem[i] = DATA_W'($urandom);
    for (int k = 0; k < 2; k++) begin
      exp_idx[k] = 0;
      done_n[k]  = 0;
      err_n[k]   = 0;
      last_wr[k] = -1;
      done_at[k] = -1;
    end
    bus1.factor     = FACTOR_W'(f);
    bus1.img_width  = DIM_W'(w);
    bus1.img_height = DIM_W'(h);
    bus1.start      = 1'b1;
    cycle();
    bus1.start = 1'b0;
  endtask

  task automatic run_job(input int w, input int h, input int f,
                         input bit poke);
    int total, budget;
    string t;
    setup_job(w, h, f);
    total  = jrej ? 0 : w * f * h * f;
    budget = total + 20;
    t = $sformatf("w%0d_h%0d_f%0d", w, h, f);
    while (budget > 0 && !(done_n[0] > 0 && done_n[1] > 0)) begin
      bus1.start = poke && bus1.busy && bus2.busy && cyc[0];
      cycle();
      budget--;
    end
    bus1.start = 1'b0;
    check({t, "_done_seen"}, (done_n[0] > 0) && (done_n[1] > 0), 1);
    cycle();
    check({t, "_busy_after"}, {bus1.busy, bus2.busy}, 0);
    repeat (3) cycle();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_writes%0d", t, k), exp_idx[k], total);
      check($sformatf("%s_dones%0d", t, k), done_n[k], 1);
      check($sformatf("%s_errs%0d", t, k), err_n[k], jrej ? 1 : 0);
      if (jrej)
        check($sformatf("%s_err_with_done%0d", t, k), done_n[k], err_n[k]);
      else
        check($sformatf("%s_done_lat%0d", t, k), done_at[k], last_wr[k] + 1);
    end
  endtask

  initial begin
    int w, h, f, before0, before1;
    reset           = 1'b1;
    bus1.start      = 1'b0;
    bus1.factor     = '0;
    bus1.img_width  = '0;
    bus1.img_height = '0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
    repeat (2) cycle();
    check_zero("reset");
    reset = 1'b0;
    cycle();

    run_job(2, 2, 2, 1'b0);
    run_job(3, 1, 1, 1'b0);
    run_job(1, 1, 4, 1'b0);
    run_job(2, 2, 3, 1'b0);
    run_job(2, 2, 0, 1'b0);
    run_job(2, 2, 5, 1'b0);
    run_job(0, 3, 2, 1'b0);
    run_job(1024, 1024, 1, 1'b0);

    setup_job(4, 4, 2);
    repeat (10) cycle();
    check("mid_run_writing", exp_idx[0] > 0, 1);
    reset = 1'b1;
    cycle();
    check_zero("mid_reset");
    reset   = 1'b0;
    before0 = exp_idx[0];
    before1 = exp_idx[1];
    repeat (6) cycle();
    check("post_reset_quiet",
          {exp_idx[0] == before0, exp_idx[1] == before1, bus1.busy}, 3'b110);
    run_job(3, 2, 2, 1'b0);

    run_job(3, 3, 2, 1'b1);
    run_job(2, 4, 4, 1'b1);

    for (int n = 0; n < 8; n++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 5);
      f = $urandom_range(0, 5);
      run_job(w, h, f, n[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
